// File: rtl/beacon_tile_sequencer.sv
// Tile enable sequencer: synchronizes and debounces per-tile switches, then staggers enables.
// Optional per-tile on-time limit is built when PHOTON_SEQ_MAXON_EN is defined.
module beacon_tile_sequencer #(
  parameter int TILE_COUNT      = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STAGGER_CYCLES  = 2_000_000,
  parameter int MAXON_CYCLES    = 2_000_000_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [TILE_COUNT-1:0]           sw_in,
  input  logic                            force_off,
  output logic [TILE_COUNT-1:0]           tile_en,
  output logic                            busy,
  output logic [$clog2(TILE_COUNT+1)-1:0] active_count,
  output logic [TILE_COUNT-1:0]           tile_fault
);

  localparam int CNT_W = $clog2(TILE_COUNT + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GAP_W = $clog2(STAGGER_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STAGGER_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  logic [TILE_COUNT-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TILE_COUNT-1:0] sw_db_q, sw_db_d;
  logic [DB_W-1:0]       db_cnt_q [TILE_COUNT];
  logic [DB_W-1:0]       db_cnt_d [TILE_COUNT];
  state_t                state_q, state_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [TILE_COUNT-1:0] tile_en_q, tile_en_d;
  logic [CNT_W-1:0]      active_count_q, active_count_d;
  logic                  busy_q, busy_d;

  logic [TILE_COUNT-1:0] fault_vec, fault_set;
  logic [TILE_COUNT-1:0] req, pending, lowest, grant;

  function automatic logic [CNT_W-1:0] popcount(input logic [TILE_COUNT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < TILE_COUNT; i++) n += CNT_W'(v[i]);
    return n;
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sync1_d  = sw_in;
    sync2_d  = sync1_q;
    sw_db_d  = sw_db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < TILE_COUNT; i++) begin
      if (sync2_q[i] != sw_db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          sw_db_d[i]  = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  assign req     = sw_db_q & ~fault_vec & {TILE_COUNT{~force_off}};
  assign pending = req & ~tile_en_q;
  // Isolates the lowest set bit of pending.
  assign lowest  = pending & (~pending + TILE_COUNT'(1));

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    grant   = '0;
    if (force_off) begin
      state_d = IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending) begin
            grant   = lowest;
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
        GAP: begin
          if (gap_q != '0) begin
            gap_d = gap_q - GAP_ONE;
          end else if (|pending) begin
            grant = lowest;
            gap_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Dropped requests clear at once, independent of the stagger gap.
    tile_en_d      = (tile_en_q & req & ~fault_set) | grant;
    active_count_d = popcount(tile_en_d);
    busy_d         = (state_q == GAP) || (|pending);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      sw_db_q        <= '0;
      // NOTE: the counter arrays are small flop banks, not RAM, so resetting them is cheap and required.
      for (int i = 0; i < TILE_COUNT; i++) db_cnt_q[i] <= '0;
      state_q        <= IDLE;
      gap_q          <= '0;
      tile_en_q      <= '0;
      active_count_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      sw_db_q        <= sw_db_d;
      db_cnt_q       <= db_cnt_d;
      state_q        <= state_d;
      gap_q          <= gap_d;
      tile_en_q      <= tile_en_d;
      active_count_q <= active_count_d;
      busy_q         <= busy_d;
    end
  end

`ifdef PHOTON_SEQ_MAXON_EN
  localparam int ON_W = $clog2(MAXON_CYCLES + 1);
  localparam logic [ON_W-1:0] ON_ONE  = ON_W'(1);
  localparam logic [ON_W-1:0] ON_LAST = ON_W'(MAXON_CYCLES - 1);

  logic [ON_W-1:0]       on_cnt_q [TILE_COUNT];
  logic [ON_W-1:0]       on_cnt_d [TILE_COUNT];
  logic [TILE_COUNT-1:0] fault_q, fault_d;

  // A fault latches until the debounced switch is seen off.
  always_comb begin
    on_cnt_d  = on_cnt_q;
    fault_set = '0;
    fault_d   = fault_q;
    for (int i = 0; i < TILE_COUNT; i++) begin
      on_cnt_d[i]  = tile_en_q[i] ? on_cnt_q[i] + ON_ONE : '0;
      fault_set[i] = tile_en_q[i] && (on_cnt_q[i] == ON_LAST);
      fault_d[i]   = fault_set[i] | (fault_q[i] & sw_db_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TILE_COUNT; i++) on_cnt_q[i] <= '0;
      fault_q <= '0;
    end else begin
      on_cnt_q <= on_cnt_d;
      fault_q  <= fault_d;
    end
  end

  assign fault_vec = fault_q;
`else
  logic maxon_unused;
  assign maxon_unused = (MAXON_CYCLES > 0);
  assign fault_set    = '0;
  assign fault_vec    = '0;
`endif

  assign tile_en      = tile_en_q;
  assign busy         = busy_q;
  assign active_count = active_count_q;
  assign tile_fault   = fault_vec;

endmodule

// File: tb/tb_beacon_tile_sequencer.sv
// Directed bench for beacon_tile_sequencer: stagger, debounce, disable-in-gap, force_off,
// reset mid-gap, and the on-time limit when PHOTON_SEQ_MAXON_EN is defined.
module tb_beacon_tile_sequencer;

  localparam int TC = 4;
  localparam int DB = 4;
  localparam int ST = 8;
  localparam int MX = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [TC-1:0] sw_in = '0;
  logic          force_off = 1'b0;
  logic [TC-1:0] tile_en;
  logic          busy;
  logic [2:0]    active_count;
  logic [TC-1:0] tile_fault;

  int checks = 0;
  int errors = 0;

  beacon_tile_sequencer #(
    .TILE_COUNT     (TC),
    .DEBOUNCE_CYCLES(DB),
    .STAGGER_CYCLES (ST),
    .MAXON_CYCLES   (MX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_in       (sw_in),
    .force_off   (force_off),
    .tile_en     (tile_en),
    .busy        (busy),
    .active_count(active_count),
    .tile_fault  (tile_fault)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_en(input string tag, input logic [TC-1:0] exp_en, input logic [2:0] exp_cnt);
    check({tag, "_en"}, 32'(tile_en), 32'(exp_en));
    check({tag, "_cnt"}, 32'(active_count), 32'(exp_cnt));
  endtask

  initial begin
    // Reset state, asserted asynchronously away from a clock edge.
    #2 rst = 1'b1;
    #1;
    check_en("rst", 4'b0000, 3'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(tile_fault), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);
    check_en("idle", 4'b0000, 3'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Staggered enable: bit0 on the 7th edge, then every 8 edges.
    sw_in = 4'b1111;
    tick(6);
    check_en("stg_pre", 4'b0000, 3'd0);
    check("stg_busy_pre", 32'(busy), 32'd0);
    tick(1);
    check_en("stg_b0", 4'b0001, 3'd1);
    check("stg_busy_on", 32'(busy), 32'd1);
    tick(7);
    check_en("stg_b0_hold", 4'b0001, 3'd1);
    tick(1);
    check_en("stg_b1", 4'b0011, 3'd2);
    tick(7);
    check_en("stg_b1_hold", 4'b0011, 3'd2);
    tick(1);
    check_en("stg_b2", 4'b0111, 3'd3);
    tick(7);
    check_en("stg_b2_hold", 4'b0111, 3'd3);
    tick(1);
    check_en("stg_b3", 4'b1111, 3'd4);
    tick(8);
    check("stg_busy_tail", 32'(busy), 32'd1);
    tick(1);
    check("stg_busy_fall", 32'(busy), 32'd0);

    // force_off kills everything next cycle; release restarts from bit0.
    force_off = 1'b1;
    tick(1);
    check_en("frc_off", 4'b0000, 3'd0);
    tick(4);
    check_en("frc_hold", 4'b0000, 3'd0);
    check("frc_busy", 32'(busy), 32'd0);
    force_off = 1'b0;
    tick(1);
    check_en("frc_rel_b0", 4'b0001, 3'd1);
    tick(7);
    check_en("frc_rel_hold", 4'b0001, 3'd1);
    tick(1);
    check_en("frc_rel_b1", 4'b0011, 3'd2);
    tick(16);
    check_en("frc_rel_all", 4'b1111, 3'd4);

    // All switches off: every tile drops together after debounce.
    sw_in = 4'b0000;
    tick(6);
    check_en("drop_pre", 4'b1111, 3'd4);
    tick(1);
    check_en("drop_all", 4'b0000, 3'd0);
    tick(10);
    check("drop_busy", 32'(busy), 32'd0);

    // Disable during GAP: bit0 drops, stagger to bit2/bit3 unaffected.
    sw_in = 4'b1111;
    tick(7);
    check_en("dis_b0", 4'b0001, 3'd1);
    tick(8);
    check_en("dis_b1", 4'b0011, 3'd2);
    tick(2);
    sw_in = 4'b1110;
    tick(5);
    check_en("dis_pre", 4'b0011, 3'd2);
    tick(1);
    check_en("dis_b2", 4'b0111, 3'd3);
    tick(1);
    check_en("dis_b0_off", 4'b0110, 3'd2);
    tick(6);
    check_en("dis_b3_pre", 4'b0110, 3'd2);
    tick(1);
    check_en("dis_b3", 4'b1110, 3'd3);

    // Debounce glitch: 3 high samples on sw_in[2] are rejected.
    sw_in = 4'b0000;
    tick(7);
    check_en("gl_clear", 4'b0000, 3'd0);
    tick(12);
    check("gl_busy_idle", 32'(busy), 32'd0);
    sw_in = 4'b0100;
    tick(3);
    sw_in = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check("gl_en", 32'(tile_en), 32'd0);
      check("gl_busy", 32'(busy), 32'd0);
    end

    // Reset mid-GAP clears outputs immediately; sequence restarts after debounce.
    sw_in = 4'b1111;
    tick(7);
    check_en("rg_b0", 4'b0001, 3'd1);
    tick(8);
    check_en("rg_b1", 4'b0011, 3'd2);
    tick(3);
    #2 rst = 1'b1;
    #1;
    check_en("rg_async", 4'b0000, 3'd0);
    check("rg_async_busy", 32'(busy), 32'd0);
    check("rg_async_fault", 32'(tile_fault), 32'd0);
    tick(2);
    check_en("rg_held", 4'b0000, 3'd0);
    rst = 1'b0;
    tick(6);
    check_en("rg_pre", 4'b0000, 3'd0);
    tick(1);
    check_en("rg_re_b0", 4'b0001, 3'd1);
    tick(8);
    check_en("rg_re_b1", 4'b0011, 3'd2);

    // On-time limit: tile0 held on.
    sw_in = 4'b0000;
    tick(7);
    check_en("mx_clear", 4'b0000, 3'd0);
    tick(20);
    sw_in = 4'b0001;
    tick(7);
    check_en("mx_on", 4'b0001, 3'd1);
    tick(63);
    check_en("mx_63", 4'b0001, 3'd1);
    check("mx_63_fault", 32'(tile_fault), 32'd0);
    tick(1);
`ifdef PHOTON_SEQ_MAXON_EN
    check_en("mx_trip", 4'b0000, 3'd0);
    check("mx_trip_fault", 32'(tile_fault), 32'b0001);
    tick(5);
    check_en("mx_trip_hold", 4'b0000, 3'd0);
    check("mx_trip_fault_hold", 32'(tile_fault), 32'b0001);
    sw_in = 4'b0000;
    tick(8);
    check("mx_fault_clr", 32'(tile_fault), 32'd0);
    sw_in = 4'b0001;
    tick(7);
    check_en("mx_reon", 4'b0001, 3'd1);
    check("mx_reon_fault", 32'(tile_fault), 32'd0);
`else
    check_en("mx_nolimit", 4'b0001, 3'd1);
    check("mx_nolimit_fault", 32'(tile_fault), 32'd0);
    tick(20);
    check_en("mx_nolimit_hold", 4'b0001, 3'd1);
    check("mx_nolimit_fault_hold", 32'(tile_fault), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
